freq_div: RTL and testbench

Clock-enable-free frequency divider producing three 50 % duty square waves (500 Hz, 2 Hz, 1 Hz) from the single system clock (40 MHz nominal). It feeds the display-multiplex logic at 500 Hz and the blink/timekeeping logic at 2 Hz and 1 Hz. All outputs are registered, so they are glitch-free.

---
 rtl/freq_div_pkg.sv | 19 +
 rtl/freq_div_if.sv | 23 ++
 rtl/clk_toggle_div.sv | 59 +++++
 rtl/freq_div.sv | 53 +++++
 tb/tb_freq_div.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/freq_div_pkg.sv
// rtl/freq_div_pkg.sv - output frequencies and half-period/width helpers for freq_div
package freq_div_pkg;

  localparam int unsigned F_500HZ = 500;
  localparam int unsigned F_2HZ   = 2;
  localparam int unsigned F_1HZ   = 1;

  // Clock cycles per half output period.
  function automatic int unsigned half_period(input int unsigned clk_hz,
                                              input int unsigned f_out);
    return clk_hz / (2 * f_out);
  endfunction

  // Counter width able to hold 0..h-1; at least one bit so h == 1 still elaborates.
  function automatic int unsigned cnt_width(input int unsigned h);
    return (h <= 1) ? 1 : $clog2(h);
  endfunction

endpackage

// File: rtl/freq_div_if.sv
// rtl/freq_div_if.sv - divided square-wave outputs (and optional strobes) of freq_div
// Signals: clk_500Hz, clk_2Hz, clk_1Hz square waves; tick_* strobes with FREQDIV_TICK_EN.
// Modports: master drives the outputs (freq_div), slave observes them.
interface freq_div_if;

  logic clk_500Hz;
  logic clk_2Hz;
  logic clk_1Hz;
`ifdef FREQDIV_TICK_EN
  logic tick_500Hz;
  logic tick_2Hz;
  logic tick_1Hz;
`endif

`ifdef FREQDIV_TICK_EN
  modport master (output clk_500Hz, clk_2Hz, clk_1Hz, tick_500Hz, tick_2Hz, tick_1Hz);
  modport slave  (input  clk_500Hz, clk_2Hz, clk_1Hz, tick_500Hz, tick_2Hz, tick_1Hz);
`else
  modport master (output clk_500Hz, clk_2Hz, clk_1Hz);
  modport slave  (input  clk_500Hz, clk_2Hz, clk_1Hz);
`endif

endinterface

// File: rtl/clk_toggle_div.sv
// rtl/clk_toggle_div.sv - one divider channel: half-period counter plus toggle register
// Ports: clk, reset (sync, active-high), wave_o (square wave, H cycles high / H low),
// tick_o (one-cycle strobe on the rising toggle, only with FREQDIV_TICK_EN).
module clk_toggle_div
  import freq_div_pkg::*;
#(
  parameter int unsigned H = 4
) (
  input  logic clk,
  input  logic reset,
`ifdef FREQDIV_TICK_EN
  output logic tick_o,
`endif
  output logic wave_o
);

  localparam int unsigned W = cnt_width(H);
  localparam logic [W-1:0] TERM = W'(H - 1);

  logic [W-1:0] count_q, count_d;
  logic         wave_q, wave_d;
  logic         term;
`ifdef FREQDIV_TICK_EN
  logic         tick_q, tick_d;
`endif

  always_comb begin
    term    = (count_q == TERM);
    count_d = term ? '0 : count_q + W'(1);
    wave_d  = wave_q ^ term;
`ifdef FREQDIV_TICK_EN
    // Strobe lands in the same register update as the 0->1 toggle.
    tick_d  = term & ~wave_q;
`endif
  end

  // Reset wins over a coincident terminal count.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      wave_q  <= 1'b0;
`ifdef FREQDIV_TICK_EN
      tick_q  <= 1'b0;
`endif
    end else begin
      count_q <= count_d;
      wave_q  <= wave_d;
`ifdef FREQDIV_TICK_EN
      tick_q  <= tick_d;
`endif
    end
  end

  assign wave_o = wave_q;
`ifdef FREQDIV_TICK_EN
  assign tick_o = tick_q;
`endif

endmodule

// File: rtl/freq_div.sv
// rtl/freq_div.sv - 500 Hz / 2 Hz / 1 Hz 50% duty divider from the system clock
// Ports: clk, reset (sync, active-high), out_if (freq_div_if.master: clk_500Hz, clk_2Hz,
// clk_1Hz, plus tick_500Hz/tick_2Hz/tick_1Hz strobes when FREQDIV_TICK_EN is defined).
// Parameter: CLK_FREQ_HZ, must be a multiple of 1000.
module freq_div
  import freq_div_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 40_000_000
) (
  input  logic      clk,
  input  logic      reset,
  freq_div_if.master out_if
);

  localparam int unsigned H500 = half_period(CLK_FREQ_HZ, F_500HZ);
  localparam int unsigned H2   = half_period(CLK_FREQ_HZ, F_2HZ);
  localparam int unsigned H1   = half_period(CLK_FREQ_HZ, F_1HZ);

  // A non-integer half period would make the outputs drift, so refuse to build.
  if ((CLK_FREQ_HZ % (2 * F_500HZ)) != 0 ||
      (CLK_FREQ_HZ % (2 * F_2HZ))   != 0 ||
      (CLK_FREQ_HZ % (2 * F_1HZ))   != 0) begin : g_bad_clk_freq
    $fatal(1, "freq_div: CLK_FREQ_HZ must be a multiple of 1000");
  end

  clk_toggle_div #(.H(H500)) u_div_500 (
    .clk    (clk),
    .reset  (reset),
`ifdef FREQDIV_TICK_EN
    .tick_o (out_if.tick_500Hz),
`endif
    .wave_o (out_if.clk_500Hz)
  );

  clk_toggle_div #(.H(H2)) u_div_2 (
    .clk    (clk),
    .reset  (reset),
`ifdef FREQDIV_TICK_EN
    .tick_o (out_if.tick_2Hz),
`endif
    .wave_o (out_if.clk_2Hz)
  );

  clk_toggle_div #(.H(H1)) u_div_1 (
    .clk    (clk),
    .reset  (reset),
`ifdef FREQDIV_TICK_EN
    .tick_o (out_if.tick_1Hz),
`endif
    .wave_o (out_if.clk_1Hz)
  );

endmodule

// File: tb/tb_freq_div.sv
// tb/tb_freq_div.sv - scoreboard bench for freq_div at CLK_FREQ_HZ = 4000
module tb_freq_div;

  typedef struct {
    int         edge_no;
    logic [2:0] val;
  } ev_t;

  logic clk;
  logic reset;
  int   edge_cnt;
  logic rst_smp;
  int   checks;
  int   errors;
  int   tog2;
  int   tog1;
  ev_t  exp_q[$];

  freq_div_if dut_if ();

  freq_div #(.CLK_FREQ_HZ(4000)) dut (
    .clk    (clk),
    .reset  (reset),
    .out_if (dut_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial edge_cnt = 0;
  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    rst_smp  <= reset;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at edge %0d", nm, act, req, edge_cnt);
    end
  endtask

  // Expected {1Hz,2Hz,500Hz} on edge n after reset release (H500=4, H2=1000, H1=2000).
  function automatic logic [2:0] model(input int n);
    logic [2:0] v;
    v[2] = ((n / 2000) % 2) == 1;
    v[1] = ((n / 1000) % 2) == 1;
    v[0] = ((n / 4) % 2) == 1;
    return v;
  endfunction

  task automatic push_phase(input int base, input int n_last);
    ev_t e;
    for (int n = 1; n <= n_last; n++) begin
      if (model(n) != model(n - 1)) begin
        e.edge_no = base + n;
        e.val     = model(n);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic push_reset_edge(input int edge_no, input int n_prev);
    ev_t e;
    if (model(n_prev) != 3'b000) begin
      e.edge_no = edge_no;
      e.val     = 3'b000;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: pops an expected event whenever the output vector changes.
  initial begin : monitor
    logic [2:0] prev;
    logic [2:0] cur;
    ev_t        e;
    prev = 3'b000;
    forever begin
      @(negedge clk);
      cur = {dut_if.clk_1Hz, dut_if.clk_2Hz, dut_if.clk_500Hz};
      if (cur !== prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_edge actual=%b required=%b at edge %0d", cur, prev, edge_cnt);
        end else begin
          e = exp_q.pop_front();
          chk("edge_cycle", edge_cnt, e.edge_no);
          chk("edge_value", {29'd0, cur}, {29'd0, e.val});
        end
        if (!rst_smp) begin
          if (cur[2] !== prev[2]) chk("1hz_on_2hz_edge", {31'd0, cur[1] ^ prev[1]}, 32'd1);
          if (cur[1] !== prev[1]) chk("2hz_on_500_edge", {31'd0, cur[0] ^ prev[0]}, 32'd1);
          if (cur[1] !== prev[1]) tog2++;
          if (cur[2] !== prev[2]) tog1++;
        end
      end
`ifdef FREQDIV_TICK_EN
      chk("ticks", {29'd0, dut_if.tick_1Hz, dut_if.tick_2Hz, dut_if.tick_500Hz},
          {29'd0, rst_smp ? 3'b000 : (cur & ~prev)});
`endif
      prev = cur;
    end
  end

  initial begin : stimulus
    int base;
    int t1;
    int t2;
    checks = 0;
    errors = 0;
    tog1   = 0;
    tog2   = 0;
    reset  = 1'b1;

    // Reset held 10 cycles: all outputs low.
    repeat (10) begin
      @(negedge clk);
      chk("reset_outputs", {29'd0, dut_if.clk_1Hz, dut_if.clk_2Hz, dut_if.clk_500Hz}, 32'd0);
    end

    // Phase 1: 8000 free-running cycles.
    reset = 1'b0;
    base  = edge_cnt;
    push_phase(base, 8000);
    t1 = tog1;
    t2 = tog2;
    for (int n = 1; n <= 8000; n++) begin
      @(negedge clk);
      if (n == 3)  chk("500_low_e3",  {31'd0, dut_if.clk_500Hz}, 32'd0);
      if (n == 4)  chk("500_rise_e4", {31'd0, dut_if.clk_500Hz}, 32'd1);
      if (n == 8)  chk("500_fall_e8", {31'd0, dut_if.clk_500Hz}, 32'd0);
      if (n == 12) chk("500_rise_e12", {31'd0, dut_if.clk_500Hz}, 32'd1);
    end
    #1;
    chk("2hz_toggles", tog2 - t2, 32'd8);
    chk("1hz_toggles", tog1 - t1, 32'd4);

    // Phase 2: one-cycle reset at n = 2500 while clk_1Hz is high.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    base  = edge_cnt;
    push_phase(base, 2499);
    push_reset_edge(base + 2500, 2499);
    repeat (2499) @(negedge clk);
    chk("pre_reset_1hz", {31'd0, dut_if.clk_1Hz}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_reset_outputs", {29'd0, dut_if.clk_1Hz, dut_if.clk_2Hz, dut_if.clk_500Hz}, 32'd0);
    reset = 1'b0;
    base  = edge_cnt;
    push_phase(base, 4000);
    for (int n = 1; n <= 4000; n++) begin
      @(negedge clk);
      if (n == 1999) chk("1hz_low_e1999", {31'd0, dut_if.clk_1Hz}, 32'd0);
      if (n == 2000) chk("1hz_rise_e2000", {31'd0, dut_if.clk_1Hz}, 32'd1);
    end

    // Phase 3: reset coincident with the clk_2Hz terminal count (n = 1000).
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    base  = edge_cnt;
    push_phase(base, 999);
    push_reset_edge(base + 1000, 999);
    repeat (999) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("tc_reset_2hz", {29'd0, dut_if.clk_1Hz, dut_if.clk_2Hz, dut_if.clk_500Hz}, 32'd0);

    // Phase 4: reset coincident with the clk_500Hz terminal count (n = 4).
    reset = 1'b0;
    base  = edge_cnt;
    push_phase(base, 3);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("tc_reset_500", {31'd0, dut_if.clk_500Hz}, 32'd0);

    // Phase 5: counters restarted from 0, so clk_500Hz rises again on edge 4.
    reset = 1'b0;
    base  = edge_cnt;
    push_phase(base, 12);
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (n == 3) chk("restart_500_low_e3",  {31'd0, dut_if.clk_500Hz}, 32'd0);
      if (n == 4) chk("restart_500_rise_e4", {31'd0, dut_if.clk_500Hz}, 32'd1);
    end
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
